// File: rtl/img_ram_streamer.sv
// Programmable strided read streamer for the image RAM: issues credit-limited reads,
// buffers returned pixels in a small FIFO and presents them on a valid/ready stream.
module img_ram_streamer #(
  parameter int ADDR_W     = 20,
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int RD_LAT     = 1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] cfg_base,
  input  logic [ADDR_W-1:0] cfg_count,
  input  logic [ADDR_W-1:0] cfg_stride,
  input  logic              cfg_dir,
  output logic              ram_rd_en,
  output logic [ADDR_W-1:0] ram_rd_addr,
  input  logic [DATA_W-1:0] ram_rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW:0] DEPTH_C = (PW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2, DONE = 2'd3} state_t;

  state_t              r_state, w_next;
  logic [ADDR_W-1:0]   r_addr, r_count, r_stride, r_issued;
  logic                r_dir;
  logic [RD_LAT-1:0]   r_pv, r_pl;
  logic [DATA_W-1:0]   r_mem [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] r_mem_last;
  logic [PW-1:0]       r_wptr, r_rptr;

  logic [PW-1:0]       w_occ;
  logic [PW:0]         w_inflight;
  logic [AW-1:0]       w_ridx, w_widx;
  logic                w_empty, w_ret, w_ret_last, w_pop, w_pop_fifo, w_push;
  logic                w_issue, w_issue_last, w_credit, w_abort, w_load;

  assign w_occ        = r_wptr - r_rptr;
  assign w_empty      = (w_occ == '0);
  assign w_ridx       = r_rptr[AW-1:0];
  assign w_widx       = r_wptr[AW-1:0];
  assign w_ret        = r_pv[RD_LAT-1];
  assign w_ret_last   = r_pl[RD_LAT-1];
  assign w_abort      = abort && (r_state != IDLE);
  assign w_load       = (r_state == IDLE) && start && !abort;
  assign w_issue_last = (r_issued == r_count - ADDR_W'(1));

  // An empty FIFO is bypassed so a returning pixel is visible in the cycle it arrives.
  assign out_valid  = !w_empty || w_ret;
  assign out_data   = !w_empty ? r_mem[w_ridx] : (w_ret ? ram_rd_data : '0);
  assign out_last   = !w_empty ? r_mem_last[w_ridx] : (w_ret && w_ret_last);
  assign w_pop      = out_valid && out_ready;
  assign w_pop_fifo = w_pop && !w_empty;
  assign w_push     = w_ret && !(w_empty && out_ready) && !w_abort;

  always_comb begin
    w_inflight = '0;
    for (int i = 0; i < RD_LAT; i++) w_inflight = w_inflight + {{PW{1'b0}}, r_pv[i]};
  end

  // Reads in flight hold a FIFO slot, so the FIFO can never overflow.
  assign w_credit = ({1'b0, w_occ} + w_inflight) < DEPTH_C;

  always_comb begin
    w_next  = r_state;
    w_issue = 1'b0;
    busy    = 1'b1;
    done    = 1'b0;
    case (r_state)
      IDLE: begin
        busy = 1'b0;
        if (w_load) w_next = (cfg_count == '0) ? DONE : RUN;
      end
      RUN: begin
        w_issue = (r_issued < r_count) && w_credit;
        if (w_issue && w_issue_last) w_next = DRAIN;
      end
      DRAIN: if (w_pop && out_last) w_next = DONE;
      DONE: begin
        done   = 1'b1;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
    if (w_abort) begin
      w_next  = IDLE;
      w_issue = 1'b0;
    end
  end

  assign ram_rd_en   = w_issue;
  assign ram_rd_addr = w_issue ? r_addr : '0;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) r_state <= IDLE;
    else      r_state <= w_next;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_addr   <= '0;
      r_count  <= '0;
      r_stride <= '0;
      r_dir    <= 1'b0;
      r_issued <= '0;
    end else if (w_load) begin
      r_addr   <= cfg_base;
      r_count  <= cfg_count;
      r_stride <= cfg_stride;
      r_dir    <= cfg_dir;
      r_issued <= '0;
    end else if (w_issue) begin
      r_addr   <= r_dir ? (r_addr - r_stride) : (r_addr + r_stride);
      r_issued <= r_issued + ADDR_W'(1);
    end
  end

  // Return pipe: tracks which cycles carry valid RAM data and whether it is the final pixel.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_pv <= '0;
      r_pl <= '0;
    end else if (w_abort) begin
      r_pv <= '0;
      r_pl <= '0;
    end else begin
      for (int i = 1; i < RD_LAT; i++) begin
        r_pv[i] <= r_pv[i-1];
        r_pl[i] <= r_pl[i-1];
      end
      r_pv[0] <= w_issue;
      r_pl[0] <= w_issue && w_issue_last;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else if (w_abort) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push)     r_wptr <= r_wptr + PW'(1);
      if (w_pop_fifo) r_rptr <= r_rptr + PW'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (w_push) begin
      r_mem[w_widx]      <= ram_rd_data;
      r_mem_last[w_widx] <= w_ret_last;
    end
  end

endmodule
